// File: rtl/down_counter.sv
// Loadable down counter / timer with terminal-count pulse, one-shot or periodic reload.
// Optional wrap_cnt output (saturating tc counter) when DOWN_COUNTER_WRAP_CNT_EN is defined.
module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             tc,
  output logic             done
`ifdef DOWN_COUNTER_WRAP_CNT_EN
  ,
  output logic [7:0]       wrap_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic             tc_reg, tc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '1;
      reload_reg <= '1;
      tc_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      reload_reg <= reload_next;
      tc_reg     <= tc_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    reload_next = reload_reg;
    tc_next     = 1'b0;
    if (load) begin
      cnt_next    = load_val;
      reload_next = load_val;
      state_next  = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) state_next = RUN;
        end
        DONE: begin
          if (start) begin
            state_next = RUN;
            cnt_next   = reload_reg;
          end
        end
        RUN, PAUSE: begin
          if (pause) begin
            state_next = PAUSE;
          end else if (cnt_reg != '0) begin
            // tc marks the decrement that lands on zero, so it is registered alongside cnt
            cnt_next   = cnt_reg - WIDTH'(1);
            state_next = RUN;
            tc_next    = (cnt_reg == WIDTH'(1));
          end else if (auto_reload) begin
            cnt_next   = reload_reg;
            state_next = RUN;
          end else begin
            state_next = DONE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign cnt  = cnt_reg;
  assign busy = (state_reg == RUN) || (state_reg == PAUSE);
  assign tc   = tc_reg;
  assign done = (state_reg == DONE);

`ifdef DOWN_COUNTER_WRAP_CNT_EN
  logic [7:0] wrap_cnt_reg, wrap_cnt_next;

  always_comb begin
    wrap_cnt_next = wrap_cnt_reg;
    if (load)
      wrap_cnt_next = 8'd0;
    else if (tc_reg && (wrap_cnt_reg != 8'hFF))
      wrap_cnt_next = wrap_cnt_reg + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wrap_cnt_reg <= 8'd0;
    else     wrap_cnt_reg <= wrap_cnt_next;
  end

  assign wrap_cnt = wrap_cnt_reg;
`endif

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: directed scenarios plus randomized run vs. a behavioural model.
// Exercises wrap_cnt too when DOWN_COUNTER_WRAP_CNT_EN is defined.
module tb_down_counter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, load, start, pause, auto_reload;
  logic [W-1:0] load_val, cnt;
  logic         busy, tc, done;
`ifdef DOWN_COUNTER_WRAP_CNT_EN
  logic [7:0]   wrap_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // behavioural model: a count value plus "running"/"finished" flags
  logic [W-1:0] m_cnt, m_reload;
  bit           m_running, m_done, m_tc;
  int           m_wrap;

  always #5 clk = ~clk;

  down_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .auto_reload(auto_reload), .cnt(cnt), .busy(busy), .tc(tc), .done(done)
`ifdef DOWN_COUNTER_WRAP_CNT_EN
    , .wrap_cnt(wrap_cnt)
`endif
  );

  task automatic model_reset();
    m_cnt = '1; m_reload = '1; m_running = 0; m_done = 0; m_tc = 0; m_wrap = 0;
  endtask

  task automatic clear_inputs();
    load = 0; start = 0; pause = 0; auto_reload = 0; load_val = '0;
  endtask

  // one clock edge; the model consumes the same inputs the DUT sees
  task automatic step();
    @(posedge clk);
    if (m_tc && m_wrap < 255) m_wrap++;
    m_tc = 0;
    if (load) begin
      m_cnt = load_val; m_reload = load_val; m_running = 0; m_done = 0; m_wrap = 0;
    end else if (!m_running) begin
      if (start) begin
        if (m_done) m_cnt = m_reload;
        m_running = 1; m_done = 0;
      end
    end else if (!pause) begin
      if (m_cnt != 0) begin
        m_cnt = m_cnt - 1'b1;
        m_tc  = (m_cnt == 0);
      end else if (auto_reload) begin
        m_cnt = m_reload;
      end else begin
        m_running = 0; m_done = 1;
      end
    end
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v, input logic ar);
    load = 1; load_val = v; auto_reload = ar; step(); load = 0;
  endtask

  task automatic do_start();
    start = 1; step(); start = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs(); model_reset();
    #12;
    checks++; if (cnt !== 4'hF) begin errors++; $display("FAIL reset_cnt got %0d want 15", cnt); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || tc !== 1'b0) begin errors++;
      $display("FAIL reset_flags got busy=%b done=%b tc=%b want 0 0 0", busy, done, tc); end
    rst = 0;
    step();
    checks++; if (cnt !== 4'hF || busy !== 1'b0) begin errors++;
      $display("FAIL reset_idle got cnt=%0d busy=%b want 15 0", cnt, busy); end
  endtask

  task automatic test_oneshot();
    do_start();
    checks++; if (cnt !== 4'hF || busy !== 1'b1) begin errors++;
      $display("FAIL oneshot_start got cnt=%0d busy=%b want 15 1", cnt, busy); end
    for (int i = 1; i <= 15; i++) begin
      step();
      checks++; if (cnt !== W'(15 - i) || tc !== (i == 15)) begin errors++;
        $display("FAIL oneshot_count i=%0d got cnt=%0d tc=%b want %0d %b", i, cnt, tc, 15 - i, i == 15); end
    end
    step();
    checks++; if (done !== 1'b1 || busy !== 1'b0 || cnt !== 4'h0 || tc !== 1'b0) begin errors++;
      $display("FAIL oneshot_done got done=%b busy=%b cnt=%0d tc=%b want 1 0 0 0", done, busy, cnt, tc); end
    step();
    checks++; if (done !== 1'b1 || cnt !== 4'h0) begin errors++;
      $display("FAIL oneshot_hold got done=%b cnt=%0d want 1 0", done, cnt); end
  endtask

  task automatic test_periodic();
    logic [W-1:0] exp_c;
    do_load(4'd5, 1'b1);
    do_start();
    checks++; if (cnt !== 4'd5 || busy !== 1'b1) begin errors++;
      $display("FAIL periodic_start got cnt=%0d busy=%b want 5 1", cnt, busy); end
    for (int i = 1; i <= 18; i++) begin
      step();
      exp_c = W'(5 - (i % 6));
      checks++; if (cnt !== exp_c || tc !== (exp_c == 0) || done !== 1'b0) begin errors++;
        $display("FAIL periodic i=%0d got cnt=%0d tc=%b done=%b want %0d %b 0", i, cnt, tc, done, exp_c, exp_c == 0); end
    end
    auto_reload = 0;
  endtask

  task automatic test_pause();
    do_load(4'd9, 1'b0);
    do_start();
    for (int i = 1; i <= 3; i++) step();
    checks++; if (cnt !== 4'd6) begin errors++; $display("FAIL pause_pre got cnt=%0d want 6", cnt); end
    pause = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (cnt !== 4'd6 || busy !== 1'b1 || tc !== 1'b0) begin errors++;
        $display("FAIL pause_hold got cnt=%0d busy=%b tc=%b want 6 1 0", cnt, busy, tc); end
    end
    pause = 0;
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) ; else begin step();
        checks++; if (cnt !== 4'd5) begin errors++; $display("FAIL pause_resume got cnt=%0d want 5", cnt); end
        continue; end
      step();
      checks++; if (cnt !== W'(5 - i) || tc !== (i == 5)) begin errors++;
        $display("FAIL pause_tail i=%0d got cnt=%0d tc=%b want %0d %b", i, cnt, tc, 5 - i, i == 5); end
    end
    step();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL pause_done got %b want 1", done); end
  endtask

  task automatic test_load_abort();
    do_load(4'd10, 1'b0);
    do_start();
    for (int i = 0; i < 7; i++) step();
    checks++; if (cnt !== 4'd3) begin errors++; $display("FAIL abort_pre got cnt=%0d want 3", cnt); end
    do_load(4'd12, 1'b0);
    checks++; if (cnt !== 4'd12 || busy !== 1'b0 || tc !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL abort_load got cnt=%0d busy=%b tc=%b done=%b want 12 0 0 0", cnt, busy, tc, done); end
    step(); step();
    checks++; if (cnt !== 4'd12 || tc !== 1'b0) begin errors++;
      $display("FAIL abort_idle got cnt=%0d tc=%b want 12 0", cnt, tc); end
    do_start();
    for (int i = 1; i <= 12; i++) begin
      step();
      checks++; if (cnt !== W'(12 - i) || tc !== (i == 12)) begin errors++;
        $display("FAIL abort_rerun i=%0d got cnt=%0d tc=%b want %0d %b", i, cnt, tc, 12 - i, i == 12); end
    end
    step();
  endtask

  task automatic test_async_reset();
    do_load(4'd10, 1'b0);
    do_start();
    for (int i = 0; i < 3; i++) step();
    checks++; if (cnt !== 4'd7 || busy !== 1'b1) begin errors++;
      $display("FAIL areset_pre got cnt=%0d busy=%b want 7 1", cnt, busy); end
    #2 rst = 1;
    #1;
    model_reset();
    checks++; if (cnt !== 4'hF || busy !== 1'b0 || done !== 1'b0 || tc !== 1'b0) begin errors++;
      $display("FAIL areset_immediate got cnt=%0d busy=%b done=%b tc=%b want 15 0 0 0", cnt, busy, done, tc); end
    #2 rst = 0;
    step(); step();
    checks++; if (cnt !== 4'hF || busy !== 1'b0) begin errors++;
      $display("FAIL areset_idle got cnt=%0d busy=%b want 15 0", cnt, busy); end
    do_start();
    step();
    checks++; if (cnt !== 4'd14 || busy !== 1'b1) begin errors++;
      $display("FAIL areset_resume got cnt=%0d busy=%b want 14 1", cnt, busy); end
  endtask

  task automatic test_zero_load();
    do_load(4'd0, 1'b0);
    do_start();
    checks++; if (busy !== 1'b1 || cnt !== 4'd0 || tc !== 1'b0) begin errors++;
      $display("FAIL zero_run got busy=%b cnt=%0d tc=%b want 1 0 0", busy, cnt, tc); end
    step();
    checks++; if (done !== 1'b1 || busy !== 1'b0 || tc !== 1'b0) begin errors++;
      $display("FAIL zero_done got done=%b busy=%b tc=%b want 1 0 0", done, busy, tc); end
    do_load(4'd0, 1'b1);
    do_start();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (cnt !== 4'd0 || busy !== 1'b1 || tc !== 1'b0 || done !== 1'b0) begin errors++;
        $display("FAIL zero_periodic got cnt=%0d busy=%b tc=%b done=%b want 0 1 0 0", cnt, busy, tc, done); end
    end
    do_load(4'd3, 1'b0);
  endtask

  task automatic test_random();
    int shown = 0;
    for (int i = 0; i < 600; i++) begin
      load        = ($urandom_range(0, 19) == 0);
      load_val    = W'($urandom);
      start       = ($urandom_range(0, 3) == 0);
      pause       = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 15) == 0) auto_reload = ~auto_reload;
      step();
      checks++;
      if (cnt !== m_cnt || busy !== m_running || done !== m_done || tc !== m_tc
`ifdef DOWN_COUNTER_WRAP_CNT_EN
          || wrap_cnt !== 8'(m_wrap)
`endif
         ) begin
        errors++;
        if (shown < 20) begin
          shown++;
          $display("FAIL random i=%0d got cnt=%0d busy=%b done=%b tc=%b want %0d %b %b %b",
                   i, cnt, busy, done, tc, m_cnt, m_running, m_done, m_tc);
        end
      end
    end
    clear_inputs();
  endtask

`ifdef DOWN_COUNTER_WRAP_CNT_EN
  task automatic test_wrap_saturate();
    do_load(4'd5, 1'b1);
    checks++; if (wrap_cnt !== 8'd0) begin errors++; $display("FAIL wrap_clear got %0d want 0", wrap_cnt); end
    do_start();
    for (int i = 1; i <= 1800; i++) begin
      step();
      if (i == 600) begin
        checks++; if (wrap_cnt !== 8'd100) begin errors++; $display("FAIL wrap_mid got %0d want 100", wrap_cnt); end
      end
    end
    checks++; if (wrap_cnt !== 8'd255) begin errors++; $display("FAIL wrap_sat got %0d want 255", wrap_cnt); end
    do_load(4'd2, 1'b0);
    checks++; if (wrap_cnt !== 8'd0) begin errors++; $display("FAIL wrap_load_clear got %0d want 0", wrap_cnt); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_load_abort();
    test_async_reset();
    test_zero_load();
    test_random();
`ifdef DOWN_COUNTER_WRAP_CNT_EN
    test_wrap_saturate();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
